// File: rtl/mask_pkg.sv
// mask_pkg: shared types and constants for the row-mask scheduler.
//   mask_type_e : operating mode encoding (repeat / sliding)
//   state_e     : scheduler FSM states
//   IMG_H_W     : width of sensor-row counters and row_idx
package mask_pkg;

  typedef enum logic [1:0] {
    MASK_REPEAT = 2'b00,
    MASK_SLIDE  = 2'b01
  } mask_type_e;

  typedef enum logic [1:0] {
    IDLE,
    PREP,
    BUILD,
    SEND
  } state_e;

  localparam int IMG_H_W = 11;

endpackage

// File: rtl/mask_row_tiler.sv
// mask_row_tiler: combinational tiling of one pattern row across a sensor row.
//   col_idx_i   : per-column (j mod pattern_w) table
//   prow_bits_i : current pattern row, bit c = pattern column c
//   shift_i     : sliding column offset, < pw_i
//   pw_i        : pattern width
//   row_o       : row mask, bit j = P[row][(col_idx[j]+shift) mod pw]
module mask_row_tiler #(
  parameter int ROW_W     = 32,
  parameter int MAX_PAT_W = 8,
  parameter int PW_BITS   = $clog2(MAX_PAT_W + 1)
) (
  input  logic [ROW_W-1:0][PW_BITS-1:0] col_idx_i,
  input  logic [MAX_PAT_W-1:0]          prow_bits_i,
  input  logic [PW_BITS-1:0]            shift_i,
  input  logic [PW_BITS-1:0]            pw_i,
  output logic [ROW_W-1:0]              row_o
);

  // Pad the row so any PW_BITS-wide column index is in range.
  localparam int EXT_W = 1 << PW_BITS;
  logic [EXT_W-1:0] bits_ext;

  always_comb begin
    bits_ext                  = '0;
    bits_ext[MAX_PAT_W-1:0]   = prow_bits_i;
  end

  for (genvar j = 0; j < ROW_W; j++) begin : g_col
    logic [PW_BITS:0]   sum;
    logic [PW_BITS-1:0] col;
    // Both terms are below pw, so one conditional subtract is the modulo.
    assign sum      = {1'b0, col_idx_i[j]} + {1'b0, shift_i};
    assign col      = (sum >= {1'b0, pw_i}) ? PW_BITS'(sum - {1'b0, pw_i})
                                            : sum[PW_BITS-1:0];
    assign row_o[j] = bits_ext[col];
  end

endmodule

// File: rtl/mask_row_scheduler.sv
// mask_row_scheduler: tiles a pattern into ROW_W-bit row masks, one per
// sensor row, and hands them to the mask generator over valid/ready.
//   clk, rst (sync, active-high), clk_en (global hold)
//   start + config (mask_type, pattern_w/h, image_sensor_h, num_frames,
//   full_pattern) : latched on start when valid, else cfg_err pulse
//   row_valid/row_ready, row_pattern, row_idx : row handshake
//   frame_done : pulse after the last row of a frame is accepted
//   busy : FSM not in IDLE
module mask_row_scheduler
  import mask_pkg::*;
#(
  parameter int ROW_W     = 32,
  parameter int MAX_PAT_W = 8,
  parameter int MAX_PAT_H = 8,
  parameter int PW_BITS   = $clog2(MAX_PAT_W + 1),
  parameter int PH_BITS   = $clog2(MAX_PAT_H + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clk_en,
  input  logic                           start,
  input  logic [1:0]                     mask_type,
  input  logic [PW_BITS-1:0]             pattern_w,
  input  logic [PH_BITS-1:0]             pattern_h,
  input  logic [IMG_H_W-1:0]             image_sensor_h,
  input  logic [7:0]                     num_frames,
  input  logic [MAX_PAT_W*MAX_PAT_H-1:0] full_pattern,
  input  logic                           row_ready,
  output logic                           row_valid,
  output logic [ROW_W-1:0]               row_pattern,
  output logic [IMG_H_W-1:0]             row_idx,
  output logic                           frame_done,
  output logic                           busy,
  output logic                           cfg_err
);

  localparam int PC_W = (ROW_W > 1) ? $clog2(ROW_W) : 1;
  localparam logic [PW_BITS-1:0] PW_ONE = PW_BITS'(1);
  localparam logic [PH_BITS-1:0] PH_ONE = PH_BITS'(1);
  localparam logic [IMG_H_W-1:0] IH_ONE = IMG_H_W'(1);

  state_e                               state_q;
  logic [MAX_PAT_H-1:0][MAX_PAT_W-1:0]  pat_q;
  logic [PW_BITS-1:0]                   pw_q, colc_q, shift_q;
  logic [PH_BITS-1:0]                   ph_q, prow_q;
  logic [IMG_H_W-1:0]                   ish_q, row_cnt_q;
  logic [7:0]                           nf_q, frame_cnt_q;
  logic                                 slide_q;
  logic [ROW_W-1:0][PW_BITS-1:0]        col_idx_q;
  logic [PC_W-1:0]                      prep_cnt_q;

  logic                                 row_valid_q, frame_done_q, busy_q, cfg_err_q;
  logic [ROW_W-1:0]                     row_pattern_q;
  logic [IMG_H_W-1:0]                   row_idx_q;

  logic                                 cfg_ok;
  logic [PW_BITS-1:0]                   colc_d, shift_d;
  logic [PH_BITS-1:0]                   prow_d;
  logic [7:0]                           frame_cnt_d;
  logic                                 frame_last;
  logic [MAX_PAT_W-1:0]                 prow_bits;
  logic [ROW_W-1:0]                     row_d;

  assign cfg_ok = (pattern_w != '0) && (pattern_w <= PW_BITS'(MAX_PAT_W)) &&
                  (pattern_h != '0) && (pattern_h <= PH_BITS'(MAX_PAT_H)) &&
                  (image_sensor_h != '0) && !mask_type[1];

  assign colc_d      = (colc_q == pw_q - PW_ONE) ? '0 : colc_q + PW_ONE;
  assign prow_d      = (prow_q == ph_q - PH_ONE) ? '0 : prow_q + PH_ONE;
  assign shift_d     = !slide_q ? '0 :
                       (shift_q == pw_q - PW_ONE) ? '0 : shift_q + PW_ONE;
  assign frame_cnt_d = frame_cnt_q + 8'd1;
  assign frame_last  = (row_cnt_q == ish_q - IH_ONE);

  always_comb begin
    prow_bits = '0;
    for (int r = 0; r < MAX_PAT_H; r++)
      if (prow_q == PH_BITS'(r)) prow_bits = pat_q[r];
  end

  mask_row_tiler #(
    .ROW_W     (ROW_W),
    .MAX_PAT_W (MAX_PAT_W),
    .PW_BITS   (PW_BITS)
  ) u_tiler (
    .col_idx_i   (col_idx_q),
    .prow_bits_i (prow_bits),
    .shift_i     (shift_q),
    .pw_i        (pw_q),
    .row_o       (row_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      pat_q         <= '0;
      pw_q          <= '0;
      ph_q          <= '0;
      ish_q         <= '0;
      nf_q          <= '0;
      slide_q       <= 1'b0;
      col_idx_q     <= '0;
      colc_q        <= '0;
      prep_cnt_q    <= '0;
      shift_q       <= '0;
      prow_q        <= '0;
      row_cnt_q     <= '0;
      frame_cnt_q   <= '0;
      row_valid_q   <= 1'b0;
      row_pattern_q <= '0;
      row_idx_q     <= '0;
      frame_done_q  <= 1'b0;
      busy_q        <= 1'b0;
      cfg_err_q     <= 1'b0;
    end else if (clk_en) begin
      cfg_err_q    <= 1'b0;
      frame_done_q <= 1'b0;
      if (start) begin
        // start wins in every state: a valid config (re)starts, an invalid one parks in IDLE.
        row_valid_q <= 1'b0;
        if (cfg_ok) begin
          pat_q       <= full_pattern;
          pw_q        <= pattern_w;
          ph_q        <= pattern_h;
          ish_q       <= image_sensor_h;
          nf_q        <= num_frames;
          slide_q     <= (mask_type == MASK_SLIDE);
          colc_q      <= '0;
          prep_cnt_q  <= '0;
          shift_q     <= '0;
          prow_q      <= '0;
          row_cnt_q   <= '0;
          frame_cnt_q <= '0;
          state_q     <= PREP;
          busy_q      <= 1'b1;
        end else begin
          cfg_err_q <= 1'b1;
          state_q   <= IDLE;
          busy_q    <= 1'b0;
        end
      end else begin
        case (state_q)
          PREP: begin
            col_idx_q[prep_cnt_q] <= colc_q;
            colc_q                <= colc_d;
            prep_cnt_q            <= prep_cnt_q + PC_W'(1);
            if (prep_cnt_q == PC_W'(ROW_W - 1)) state_q <= BUILD;
          end
          BUILD: begin
            row_pattern_q <= row_d;
            row_idx_q     <= row_cnt_q;
            row_valid_q   <= 1'b1;
            state_q       <= SEND;
          end
          SEND: begin
            if (row_valid_q && row_ready) begin
              row_valid_q <= 1'b0;
              state_q     <= BUILD;
              if (frame_last) begin
                frame_done_q <= 1'b1;
                frame_cnt_q  <= frame_cnt_d;
                row_cnt_q    <= '0;
                prow_q       <= '0;
                shift_q      <= shift_d;
                if (nf_q != 8'd0 && frame_cnt_d == nf_q) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                end
              end else begin
                row_cnt_q <= row_cnt_q + IH_ONE;
                prow_q    <= prow_d;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign row_valid   = row_valid_q;
  assign row_pattern = row_pattern_q;
  assign row_idx     = row_idx_q;
  assign frame_done  = frame_done_q;
  assign busy        = busy_q;
  assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_mask_row_scheduler.sv
// tb_mask_row_scheduler: directed vectors with hand-computed rows for
// repeat, sliding, backpressure, invalid config, abort, continuous
// run with clk_en gating, and mid-row reset.
module tb_mask_row_scheduler;

  logic        clk = 1'b0;
  logic        rst, clk_en, start, row_ready;
  logic [1:0]  mask_type;
  logic [3:0]  pattern_w, pattern_h;
  logic [10:0] image_sensor_h;
  logic [7:0]  num_frames;
  logic [63:0] full_pattern;
  logic        row_valid, frame_done, busy, cfg_err;
  logic [31:0] row_pattern;
  logic [10:0] row_idx;

  int n_run  = 0;
  int n_fail = 0;

  localparam logic [31:0] R0  = 32'h4924_9249;  // P row0 = c0 set, pw=3
  localparam logic [31:0] R1  = 32'hB6DB_6DB6;  // inverse row
  localparam logic [31:0] R0S = 32'h2492_4924;  // row0 shifted by one column
  localparam logic [63:0] PAT = 64'h0601;       // row0=3'b001, row1=3'b110

  always #5 clk = ~clk;

  mask_row_scheduler dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .start(start),
    .mask_type(mask_type), .pattern_w(pattern_w), .pattern_h(pattern_h),
    .image_sensor_h(image_sensor_h), .num_frames(num_frames),
    .full_pattern(full_pattern), .row_ready(row_ready),
    .row_valid(row_valid), .row_pattern(row_pattern), .row_idx(row_idx),
    .frame_done(frame_done), .busy(busy), .cfg_err(cfg_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic cfg(input logic [1:0] mt, input logic [3:0] pw, input logic [3:0] ph,
                     input logic [10:0] ish, input logic [7:0] nf, input logic [63:0] pat);
    mask_type = mt; pattern_w = pw; pattern_h = ph;
    image_sensor_h = ish; num_frames = nf; full_pattern = pat;
  endtask

  task automatic pulse_start;
    start = 1'b1; step; start = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!row_valid && n < 200) begin step; n++; end
    if (!row_valid) chk("wait_valid_timeout", row_valid, 1);
  endtask

  // Expects row_ready=1: the edge after valid is the accepting edge.
  task automatic take_row(input string tag, input logic [31:0] ep, input logic [10:0] ei,
                          input logic fd, input logic bz);
    int n;
    wait_valid(n);
    chk({tag, "_pat"}, row_pattern, ep);
    chk({tag, "_idx"}, row_idx, ei);
    step;
    chk({tag, "_fdone"}, frame_done, fd);
    chk({tag, "_busy"}, busy, bz);
  endtask

  initial begin
    int n, seen, rows, frames;
    logic [63:0] snap;
    logic en, acc;
    rst = 1'b1; clk_en = 1'b1; start = 1'b0; row_ready = 1'b0;
    cfg(2'b00, 4'd0, 4'd0, 11'd0, 8'd0, 64'd0);
    step; step;
    chk("rst_outs", {row_valid, row_pattern, row_idx, frame_done, busy, cfg_err}, 0);
    rst = 1'b0;
    step;
    chk("idle_busy", busy, 0);

    // Repeat mode, 4 rows, 1 frame.
    cfg(2'b00, 4'd3, 4'd2, 11'd4, 8'd1, PAT);
    row_ready = 1'b1;
    pulse_start;
    chk("t1_busy", busy, 1);
    wait_valid(n);
    chk("t1_latency", n + 1, 34);
    for (int i = 0; i < 4; i++)
      take_row("t1_row", (i % 2) ? R1 : R0, 11'(i), i == 3, i != 3);
    step;
    chk("t1_fdone_pulse", frame_done, 0);
    chk("t1_valid_off", row_valid, 0);

    // Sliding mode, 1 row per frame, 2 frames.
    cfg(2'b01, 4'd3, 4'd2, 11'd1, 8'd2, PAT);
    pulse_start;
    take_row("t2_f0", R0, 11'd0, 1'b1, 1'b1);
    take_row("t2_f1", R0S, 11'd0, 1'b1, 1'b0);
    step;
    chk("t2_idle", busy, 0);

    // Backpressure on row 1.
    cfg(2'b00, 4'd3, 4'd2, 11'd4, 8'd1, PAT);
    pulse_start;
    take_row("t3_r0", R0, 11'd0, 1'b0, 1'b1);
    row_ready = 1'b0;
    wait_valid(n);
    for (int k = 0; k < 5; k++) begin
      step;
      chk("t3_hold", {row_valid, row_pattern, row_idx}, {1'b1, R1, 11'd1});
    end
    row_ready = 1'b1;
    step;
    chk("t3_drop", row_valid, 0);
    take_row("t3_r2", R0, 11'd2, 1'b0, 1'b1);
    take_row("t3_r3", R1, 11'd3, 1'b1, 1'b0);

    // Invalid configurations.
    for (int c = 0; c < 2; c++) begin
      if (c == 0) cfg(2'b00, 4'd0, 4'd2, 11'd4, 8'd1, PAT);
      else        cfg(2'b10, 4'd3, 4'd2, 11'd4, 8'd1, PAT);
      pulse_start;
      chk("t4_cfg_err", cfg_err, 1);
      chk("t4_busy", busy, 0);
      step;
      chk("t4_err_pulse", cfg_err, 0);
      seen = 0;
      for (int k = 0; k < 40; k++) begin
        if (row_valid || busy) seen = 1;
        step;
      end
      chk("t4_no_activity", seen, 0);
    end

    // Abort mid-frame while in SEND.
    cfg(2'b00, 4'd3, 4'd2, 11'd4, 8'd1, PAT);
    pulse_start;
    take_row("t5_r0", R0, 11'd0, 1'b0, 1'b1);
    row_ready = 1'b0;
    wait_valid(n);
    chk("t5_r1_idx", row_idx, 1);
    cfg(2'b00, 4'd2, 4'd1, 11'd4, 8'd1, 64'h01);
    pulse_start;
    chk("t5_valid_drop", row_valid, 0);
    chk("t5_busy", busy, 1);
    row_ready = 1'b1;
    wait_valid(n);
    chk("t5_latency", n + 1, 34);
    chk("t5_new_pat", row_pattern, 32'h5555_5555);
    chk("t5_new_idx", row_idx, 0);
    rst = 1'b1; step; rst = 1'b0;

    // Continuous run with clk_en gating; model tracks accepted rows.
    cfg(2'b00, 4'd3, 4'd2, 11'd2, 8'd0, PAT);
    row_ready = 1'b1;
    pulse_start;
    rows = 0; frames = 0;
    for (int i = 0; i < 300; i++) begin
      en = (i % 4) != 3;
      clk_en = en;
      snap = {row_valid, row_pattern, row_idx, frame_done, busy};
      if (row_valid) begin
        chk("t6_pat", row_pattern, (rows % 2) ? R1 : R0);
        chk("t6_idx", row_idx, 11'(rows % 2));
      end
      acc = en & row_valid & row_ready;
      step;
      if (!en) chk("t6_freeze", {row_valid, row_pattern, row_idx, frame_done, busy}, snap);
      else if (acc) begin
        rows++;
        chk("t6_fdone", frame_done, (rows % 2) == 0);
        if (rows % 2 == 0) frames++;
      end else chk("t6_fdone_idle", frame_done, 0);
    end
    chk("t6_many_frames", frames >= 5, 1);
    chk("t6_busy", busy, 1);

    // Mid-row reset, with clk_en low to show rst priority.
    clk_en = 1'b1;
    wait_valid(n);
    clk_en = 1'b0; rst = 1'b1;
    step;
    rst = 1'b0;
    chk("t7_rst_outs", {row_valid, row_pattern, row_idx, frame_done, busy, cfg_err}, 0);
    clk_en = 1'b1;
    for (int k = 0; k < 3; k++) step;
    chk("t7_stays_idle", {row_valid, busy}, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
